tt_um_ha_cd: RTL and testbench

// - Tiny Tapeout user tile: registered half adder plus programmable clock divider.
// - Sits directly under the TT harness and drives the uo_out and uio pads.
// - The half adder takes two input bits.
// - The divider generates a divided clock, a one-cycle tick and an optional tick counter.

---
 rtl/tt_um_ha_cd_if.sv | 13 +
 rtl/tt_um_ha_cd.sv | 91 +++++++++
 tb/tb_tt_um_ha_cd.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tt_um_ha_cd_if.sv
// Pad bundle for the half-adder / clock-divider tile: enable, dedicated inputs,
// dedicated outputs and the bidirectional uio pad group.
interface tt_um_ha_cd_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_ha_cd.sv
// Tiny Tapeout tile: registered half adder plus programmable clock divider.
// Define HA_CD_TICK_CNT_EN to add the tick event counter driven onto the uio pads.
module tt_um_ha_cd #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  tt_um_ha_cd_if.slave io
);

  logic             a;
  logic             b;
  logic             div_en;
  logic             div_clr;
  logic [DIV_W-1:0] n_sel;
  logic             terminal;

  logic             sum;
  logic             carry;
  logic             clk_div;
  logic             tick;
  logic [DIV_W-1:0] cnt;

  assign a       = io.ui_in[0];
  assign b       = io.ui_in[1];
  assign div_en  = io.ui_in[2];
  assign div_clr = io.ui_in[3];
  assign n_sel   = DIV_W'(io.ui_in[7:4]);

  // >= rather than == so that lowering N below the running count wraps at once.
  assign terminal = (cnt >= n_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= 1'b0;
      carry   <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
      cnt     <= '0;
    end else if (io.ena) begin
      sum   <= a ^ b;
      carry <= a & b;
      if (div_clr) begin
        cnt     <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
      end else if (div_en) begin
        if (terminal) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_div <= ~clk_div;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

  assign io.uo_out = {4'(cnt), tick, clk_div, carry, sum};

`ifdef HA_CD_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt;

  // Counts the same terminal events that raise tick, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (io.ena) begin
      if (div_clr) begin
        tick_cnt <= '0;
      end else if (div_en && terminal) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign io.uio_out = 8'(tick_cnt);
  assign io.uio_oe  = 8'hFF;
`else
  assign io.uio_out = 8'h00;
  assign io.uio_oe  = 8'h00;
`endif

  logic unused_pads;
  assign unused_pads = ^io.uio_in;

endmodule

// File: tb/tb_tt_um_ha_cd.sv
// Self-checking bench for tt_um_ha_cd: a cycle model feeds a scoreboard queue,
// plus directed checks of the half adder, divider periods and enable freeze.
module tb_tt_um_ha_cd;

  logic clk = 1'b0;
  logic rst;

  tt_um_ha_cd_if io();

  tt_um_ha_cd dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic       m_sum, m_carry, m_clk_div, m_tick;
  logic [3:0] m_cnt;
  logic [7:0] m_tick_cnt;

`ifdef HA_CD_TICK_CNT_EN
  localparam logic [7:0] OE_EXP = 8'hFF;
  localparam bit         FEAT   = 1'b1;
`else
  localparam logic [7:0] OE_EXP = 8'h00;
  localparam bit         FEAT   = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] ui);
    exp_t ex;
    exp_t got;
    rst       = r;
    io.ena    = e;
    io.ui_in  = ui;
    io.uio_in = 8'($urandom);
    if (r) begin
      m_sum = 0; m_carry = 0; m_clk_div = 0; m_tick = 0; m_cnt = 0; m_tick_cnt = 0;
    end else if (e) begin
      m_sum   = ui[0] ^ ui[1];
      m_carry = ui[0] & ui[1];
      if (ui[3]) begin
        m_cnt = 0; m_clk_div = 0; m_tick = 0; m_tick_cnt = 0;
      end else if (ui[2]) begin
        if (m_cnt >= ui[7:4]) begin
          m_cnt      = 0;
          m_tick     = 1;
          m_clk_div  = ~m_clk_div;
          m_tick_cnt = m_tick_cnt + 8'd1;
        end else begin
          m_cnt  = m_cnt + 4'd1;
          m_tick = 0;
        end
      end else begin
        m_tick = 0;
      end
    end
    ex.uo  = {m_cnt, m_tick, m_clk_div, m_carry, m_sum};
    ex.uio = FEAT ? m_tick_cnt : 8'h00;
    ex.oe  = OE_EXP;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput("sb_uo", {8'h00, io.uo_out}, {8'h00, got.uo});
    checkOutput("sb_uio", {8'h00, io.uio_out}, {8'h00, got.uio});
    checkOutput("sb_oe", {8'h00, io.uio_oe}, {8'h00, got.oe});
  endtask

  initial begin
    logic [7:0] held_uo;
    logic [7:0] held_uio;
    logic [7:0] ha_in  [4];
    logic [1:0] ha_exp [4];
    ha_in[0] = 8'h00; ha_exp[0] = 2'b00;
    ha_in[1] = 8'h01; ha_exp[1] = 2'b01;
    ha_in[2] = 8'h02; ha_exp[2] = 2'b01;
    ha_in[3] = 8'h03; ha_exp[3] = 2'b10;

    rst = 1'b1; io.ena = 1'b1; io.ui_in = 8'h00; io.uio_in = 8'h00;

    // Reset, then the first free cycle must show all-zero pads.
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("reset_uo", {8'h00, io.uo_out}, 16'h0000);
    checkOutput("reset_uio", {8'h00, io.uio_out}, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, ha_in[i]);
      checkOutput($sformatf("ha_ab%0d", i), {14'h0, io.uo_out[1:0]}, {14'h0, ha_exp[i]});
    end

    // N=3 from a cleared divider: ticks on 4, 8, 12; count 1,2,3,0; clk_div period 8.
    applyStimulus(1'b0, 1'b1, 8'h38);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h34);
      checkOutput($sformatf("n3_tick_k%0d", k), {15'h0, io.uo_out[3]}, {15'h0, (k % 4) == 0});
      checkOutput($sformatf("n3_cnt_k%0d", k), {12'h0, io.uo_out[7:4]}, 16'(k % 4));
      checkOutput($sformatf("n3_clkdiv_k%0d", k), {15'h0, io.uo_out[2]}, {15'h0, ((k / 4) % 2) == 1});
    end

    // Freeze mid-count while a,b toggle; nothing may move until ena returns.
    applyStimulus(1'b0, 1'b1, 8'h34);
    applyStimulus(1'b0, 1'b1, 8'h34);
    held_uo  = io.uo_out;
    held_uio = io.uio_out;
    checkOutput("pre_freeze_cnt", {12'h0, held_uo[7:4]}, 16'd2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h34 | 8'(k[1:0]));
      checkOutput($sformatf("freeze_uo%0d", k), {8'h00, io.uo_out}, {8'h00, held_uo});
      checkOutput($sformatf("freeze_uio%0d", k), {8'h00, io.uio_out}, {8'h00, held_uio});
    end
    applyStimulus(1'b0, 1'b1, 8'h37);
    checkOutput("unfreeze_ha", {14'h0, io.uo_out[1:0]}, 16'b10);
    checkOutput("unfreeze_cnt", {12'h0, io.uo_out[7:4]}, 16'd3);

    // Clear wins over enable.
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkOutput("clr_over_en", {8'h00, io.uo_out}, 16'h0000);

    // N=0: tick every cycle, clk_div toggling each cycle.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h04);
      checkOutput($sformatf("n0_tick_k%0d", k), {15'h0, io.uo_out[3]}, 16'd1);
      checkOutput($sformatf("n0_clkdiv_k%0d", k), {15'h0, io.uo_out[2]}, 16'(k % 2));
    end

    // Count up to 9 with N=15, then drop N to 2: wraps immediately.
    applyStimulus(1'b0, 1'b1, 8'h08);
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 8'hF4);
    checkOutput("cnt_at_9", {12'h0, io.uo_out[7:4]}, 16'd9);
    applyStimulus(1'b0, 1'b1, 8'h24);
    checkOutput("nchange_cnt", {12'h0, io.uo_out[7:4]}, 16'd0);
    checkOutput("nchange_tick", {15'h0, io.uo_out[3]}, 16'd1);

    // 300 ticks at N=0 after a clear.
    applyStimulus(1'b0, 1'b1, 8'h08);
    for (int k = 0; k < 300; k++) applyStimulus(1'b0, 1'b1, 8'h04);
    checkOutput("tickcnt_uio", {8'h00, io.uio_out}, FEAT ? 16'd44 : 16'd0);
    checkOutput("tickcnt_oe", {8'h00, io.uio_oe}, FEAT ? 16'h00FF : 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
